// File: rtl/clock_divider_bank.sv
// clock_divider_bank: bank of 50%-duty clock dividers with glitch-free run-time reload and global sync.
module clock_divider_bank #(
  parameter int CHANNELS = 4,
  parameter int DIV_WIDTH = 16,
  parameter int DEFAULT_HALF = 1,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  enable,
  input  logic                 sync,
  input  logic                 div_load,
  input  logic [CW-1:0]        div_ch,
  input  logic [DIV_WIDTH-1:0] div_in,
  output logic [CHANNELS-1:0]  div_pending,
  output logic                 div_err,
  output logic [CHANNELS-1:0]  clk_out,
  output logic [CHANNELS-1:0]  tick
);
  logic load_ok;
  logic div_err_q;
  assign load_ok = div_load && (32'(div_ch) < 32'(CHANNELS)) && (div_in != '0);
  assign div_err = div_err_q;
  always_ff @(posedge clock)
    div_err_q <= reset ? 1'b0 : div_load && !load_ok;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, half_q, half_d, pval_q, pval_d;
    logic pend_q, pend_d, out_q, out_d, tick_q, tick_d;
    logic ld, bnd, adv, tog, apply;
    always_comb begin
      ld = load_ok && (div_ch == CW'(c));
      bnd = cnt_q == half_q - DIV_WIDTH'(1);
      adv = enable[c] && !sync;
      tog = adv && bnd;
      // a pending ratio is taken at a toggle boundary, while idle, or on sync
      apply = pend_q && (sync || !enable[c] || bnd);
      cnt_d = (adv && !bnd) ? cnt_q + DIV_WIDTH'(1) : '0;
      out_d = sync ? 1'b0 : out_q ^ tog;
      tick_d = tog && !out_q;
      half_d = (sync && ld) ? div_in : apply ? pval_q : half_q;
      pend_d = (ld && !sync) ? 1'b1 : apply ? 1'b0 : pend_q;
      pval_d = (ld && !sync) ? div_in : pval_q;
    end
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_q  <= '0;
        half_q <= DIV_WIDTH'(DEFAULT_HALF);
        pval_q <= '0;
        pend_q <= 1'b0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        half_q <= half_d;
        pval_q <= pval_d;
        pend_q <= pend_d;
        out_q  <= out_d;
        tick_q <= tick_d;
      end
    end
    assign clk_out[c] = out_q;
    assign tick[c] = tick_q;
    assign div_pending[c] = pend_q;
  end
endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: scoreboard bench comparing the divider bank to a countdown reference model.
module tb_clock_divider_bank;
  localparam int CH = 5;
  localparam int DW = 16;
  localparam int CW = 3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [CH-1:0] enable = '0;
  logic sync = 1'b0;
  logic div_load = 1'b0;
  logic [CW-1:0] div_ch = '0;
  logic [DW-1:0] div_in = '0;
  logic [CH-1:0] div_pending, clk_out, tick;
  logic div_err;
  typedef struct {
    logic [CH-1:0] co;
    logic [CH-1:0] tk;
    logic [CH-1:0] pd;
    logic er;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int m_lvl[CH], m_rem[CH], m_half[CH], m_pval[CH];
  bit m_pend[CH];
  clock_divider_bank #(.CHANNELS(CH), .DIV_WIDTH(DW), .DEFAULT_HALF(1)) dut (
    .clock(clock), .reset(reset), .enable(enable), .sync(sync),
    .div_load(div_load), .div_ch(div_ch), .div_in(div_in),
    .div_pending(div_pending), .div_err(div_err), .clk_out(clk_out), .tick(tick)
  );
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [CH-1:0] a, input logic [CH-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", n, $time, a, e);
    end
  endtask
  initial forever begin
    exp_t e;
    @(posedge clock);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("clk_out", clk_out, e.co);
      chk("tick", tick, e.tk);
      chk("div_pending", div_pending, e.pd);
      chk("div_err", CH'(div_err), CH'(e.er));
    end
  end
  // Reference: each channel counts down the cycles left in its current half period.
  task automatic step(input bit r, input logic [CH-1:0] en, input bit sy, input bit ld, input int ch, input int din);
    exp_t e;
    bit valid;
    reset = r; enable = en; sync = sy; div_load = ld;
    div_ch = CW'(ch); div_in = DW'(din);
    valid = ld && ch < CH && din != 0;
    e.er = !r && ld && !valid;
    e.tk = '0;
    for (int c = 0; c < CH; c++) begin
      if (r) begin
        m_half[c] = 1; m_rem[c] = 1; m_lvl[c] = 0; m_pend[c] = 0; m_pval[c] = 0;
      end else if (sy) begin
        m_half[c] = (valid && ch == c) ? din : m_pend[c] ? m_pval[c] : m_half[c];
        m_pend[c] = 0; m_lvl[c] = 0; m_rem[c] = m_half[c];
      end else begin
        if (!en[c]) begin
          if (m_pend[c]) begin m_half[c] = m_pval[c]; m_pend[c] = 0; end
          m_rem[c] = m_half[c];
        end else begin
          m_rem[c]--;
          if (m_rem[c] == 0) begin
            m_lvl[c] ^= 1;
            e.tk[c] = m_lvl[c] == 1;
            if (m_pend[c]) begin m_half[c] = m_pval[c]; m_pend[c] = 0; end
            m_rem[c] = m_half[c];
          end
        end
        if (valid && ch == c) begin m_pend[c] = 1; m_pval[c] = din; end
      end
      e.co[c] = m_lvl[c][0];
      e.pd[c] = m_pend[c];
    end
    q.push_back(e);
    @(negedge clock);
  endtask
  task automatic run(input int n, input logic [CH-1:0] en);
    for (int i = 0; i < n; i++) step(0, en, 0, 0, 0, 0);
  endtask
  initial begin
    @(negedge clock);
    step(1, '1, 0, 0, 0, 0);
    step(1, '1, 0, 0, 0, 0);
    run(8, '1);
    step(0, '0, 0, 1, 0, 3);
    step(0, '0, 0, 1, 1, 5);
    run(2, '0);
    run(24, '1);
    step(0, '1, 0, 1, 2, 4);
    run(13, '1);
    step(0, '1, 0, 1, 2, 2);
    run(12, '1);
    step(0, '1, 0, 1, CH, 4);
    step(0, '1, 0, 1, 2, 0);
    step(0, '1, 0, 1, 7, 0);
    run(3, '1);
    step(0, '1, 0, 1, 0, 3);
    step(0, '1, 0, 1, 1, 5);
    step(0, '1, 0, 1, 2, 7);
    run(20, '1);
    step(0, '1, 1, 1, 3, 2);
    run(16, '1);
    run(2, '1);
    run(5, 5'b11101);
    run(10, '1);
    step(1, '1, 0, 0, 0, 0);
    run(4, '1);
    for (int i = 0; i < 3000; i++) begin
      logic [CH-1:0] en;
      for (int c = 0; c < CH; c++) en[c] = $urandom_range(99) < 90;
      step($urandom_range(999) < 5, en, $urandom_range(99) < 2, $urandom_range(99) < 10,
           int'($urandom_range(7)), int'($urandom_range(6)));
    end
    run(2, '1);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d queued expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
